cga_line_doubler: RTL and testbench
===================================

CGA_LINE_DOUBLER -- requirements
Module: cga_line_doubler

Interface
REQ-001 SHALL have parameter LINE_PIX, default 912, giving the maximum CGA pixels stored per line and the output line length in clk cycles.
REQ-002 SHALL have parameter HSYNC_W, default 108, giving the width of vga_hsync in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic, nominally 28.636 MHz, twice the CGA pixel rate.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cga_pix_en, input, 1 bit: CGA pixel strobe, high at most every 2nd clk cycle.
REQ-006 SHALL have port cga_video, input, 4 bits: CGA IRGB pixel, valid when cga_pix_en is high.
REQ-007 SHALL have port cga_hsync, input, 1 bit: CGA horizontal sync, active-high.
REQ-008 SHALL have port cga_vsync, input, 1 bit: CGA vertical sync, active-high.
REQ-009 SHALL have port vga_video, output, 4 bits: doubled-rate IRGB pixel, fed to the palette/DAC stage.
REQ-010 SHALL have port vga_hsync, output, 1 bit: regenerated 31 kHz horizontal sync, active-high.
REQ-011 SHALL have port vga_vsync, output, 1 bit: vertical sync aligned to vga_video.

Function
REQ-012 SHALL contain two line banks, each LINE_PIX x 4 bits, plus a 1-bit write-bank pointer wr_bank.
REQ-013 SHALL register cga_hsync once and define an hsync edge as cga_hsync=1 with the registered copy=0.
REQ-014 On an hsync edge, SHALL toggle wr_bank, store the finished line's wr_x as that bank's length (len[bank]), clear wr_x to 0 and clear rd_x to 0.
REQ-015 On a cycle with cga_pix_en=1 and wr_x<LINE_PIX, SHALL write cga_video to bank[wr_bank][wr_x] and increment wr_x.
REQ-016 On a cycle with cga_pix_en=1 and wr_x=LINE_PIX, SHALL drop the pixel and hold wr_x at LINE_PIX (saturate, no wrap).
REQ-017 When an hsync edge and cga_pix_en coincide, SHALL write the pixel to address 0 of the new bank and set wr_x to 1.
REQ-018 SHALL advance rd_x by 1 every clk cycle, wrapping from LINE_PIX-1 to 0, so each stored line is read twice per CGA line.
REQ-019 An hsync edge SHALL override the wrap and force rd_x to 0, even mid-line.
REQ-020 SHALL read bank[~wr_bank][rd_x] with a synchronous read of 1-cycle latency.
REQ-021 If rd_x >= len[~wr_bank], SHALL produce 4'h0 instead of the stored data.
REQ-022 SHALL register vga_video, giving a total latency of 2 clk cycles from rd_x to vga_video.
REQ-023 SHALL set vga_hsync = (rd_x < HSYNC_W), delayed 2 cycles to stay aligned with vga_video.
REQ-024 SHALL set vga_vsync = cga_vsync delayed 3 cycles: 1 for input registering plus 2 for pipeline alignment.
REQ-025 SHALL make vga_video, vga_hsync and vga_vsync all register outputs, with no combinational path from any input.

Reset
REQ-026 On reset asserted, SHALL asynchronously clear wr_x, rd_x, wr_bank, both len values, the hsync/vsync delay registers, vga_video (4'h0), vga_hsync (0) and vga_vsync (0).
REQ-027 Line bank contents SHALL NOT need clearing; the len values being 0 forces output to 4'h0 until a full line has been stored.
REQ-028 On reset asserted mid-line, SHALL discard the partial line.
REQ-029 After reset is released, the first hsync edge SHALL start line capture, and output SHALL show black until the second hsync edge.

Verification
REQ-030 Reset check: assert reset with random inputs -> all outputs 0 in the same cycle; after release with no hsync, vga_video stays 4'h0 and vga_hsync pulses every 912 clk for 108 clk.
REQ-031 Basic doubling: write a line of 912 pixels with values x mod 16 (pix_en on alternate cycles), then an hsync edge -> vga_video shows 0,1,..,F,0.. twice, starting 2 clk after rd_x=0, each copy 912 clk long.
REQ-032 Short line: store 400 pixels then an hsync edge -> output pixels 400..911 of each copy read 4'h0.
REQ-033 Overflow: 1000 pix_en strobes in one line -> only pixels 0..911 stored; pixels 912..999 dropped; no wrap corruption of address 0.
REQ-034 Simultaneous events: pix_en coincident with an hsync edge carrying value 4'hA -> new line pixel 0 = 4'hA on readout; rd_x restarts at 0 and vga_hsync rises 2 cycles later.
REQ-035 Reset mid-line: assert reset after 300 pixels of line 2 -> outputs 0 immediately; the previously stored line is not displayed after release; vga_vsync cleared and then re-aligned at 3-cycle delay.

Source files
------------

// File: rtl/cga_line_doubler.sv
// CGA-to-VGA scan doubler: captures each CGA line into one of two banks and
// replays the other bank twice per CGA line at the doubled clock rate.
module cga_line_doubler #(
    parameter int LINE_PIX = 912,
    parameter int HSYNC_W  = 108
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cga_pix_en,
    input  logic [3:0] cga_video,
    input  logic       cga_hsync,
    input  logic       cga_vsync,
    output logic [3:0] vga_video,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    localparam int X_W = $clog2(LINE_PIX + 1);
    localparam int A_W = $clog2(LINE_PIX);
    localparam logic [X_W-1:0] X_MAX  = X_W'(LINE_PIX);
    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_PIX - 1);
    localparam logic [X_W-1:0] HS_END = X_W'(HSYNC_W);

    logic [3:0]     bank0_r [LINE_PIX];
    logic [3:0]     bank1_r [LINE_PIX];
    logic [3:0]     rd_data_r;
    logic [3:0]     vga_video_r;
    logic           vga_hsync_r;
    logic           vga_vsync_r;
    logic           hs_r;
    logic           vs_r;
    logic           vs_d1_r;
    logic           hs_d1_r;
    logic           blank_r;
    logic           cap_en_r;
    logic           wr_bank_r;
    logic [X_W-1:0] wr_x_r;
    logic [X_W-1:0] rd_x_r;
    logic [X_W-1:0] len0_r;
    logic [X_W-1:0] len1_r;

    logic           hs_edge_s;
    logic           rd_bank_s;
    logic [X_W-1:0] rd_len_s;
    logic           we_s;
    logic           wsel_s;
    logic [A_W-1:0] waddr_s;
    logic [X_W-1:0] wr_x_nxt_s;
    logic [X_W-1:0] rd_x_nxt_s;

    // Edge detect, bank selection, write address and read counter next-state
    always_comb begin
        hs_edge_s  = cga_hsync & ~hs_r;
        rd_bank_s  = ~wr_bank_r;
        we_s       = 1'b0;
        wsel_s     = wr_bank_r;
        waddr_s    = wr_x_r[A_W-1:0];
        wr_x_nxt_s = wr_x_r;
        rd_x_nxt_s = rd_x_r + X_W'(1);

        if (rd_bank_s) begin
            rd_len_s = len1_r;
        end else begin
            rd_len_s = len0_r;
        end

        // A coincident pixel lands at address 0 of the bank that is about to open
        if (hs_edge_s) begin
            wsel_s     = ~wr_bank_r;
            waddr_s    = '0;
            we_s       = cga_pix_en;
            wr_x_nxt_s = cga_pix_en ? X_W'(1) : X_W'(0);
        end else if (cga_pix_en && cap_en_r && (wr_x_r < X_MAX)) begin
            we_s       = 1'b1;
            wr_x_nxt_s = wr_x_r + X_W'(1);
        end else begin
            wr_x_nxt_s = wr_x_r;
        end

        if (hs_edge_s) begin
            rd_x_nxt_s = '0;
        end else if (rd_x_r == X_LAST) begin
            rd_x_nxt_s = '0;
        end else begin
            rd_x_nxt_s = rd_x_r + X_W'(1);
        end
    end

    // Line bank storage and one-cycle synchronous readout of the display bank
    always_ff @(posedge clk) begin
        if (we_s) begin
            if (wsel_s) begin
                bank1_r[waddr_s] <= cga_video;
            end else begin
                bank0_r[waddr_s] <= cga_video;
            end
        end
        if (rd_bank_s) begin
            rd_data_r <= bank1_r[rd_x_r[A_W-1:0]];
        end else begin
            rd_data_r <= bank0_r[rd_x_r[A_W-1:0]];
        end
    end

    // Capture/readout control state and the aligned output pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            vs_d1_r     <= 1'b0;
            hs_d1_r     <= 1'b0;
            blank_r     <= 1'b1;
            cap_en_r    <= 1'b0;
            wr_bank_r   <= 1'b0;
            wr_x_r      <= '0;
            rd_x_r      <= '0;
            len0_r      <= '0;
            len1_r      <= '0;
            vga_video_r <= 4'h0;
            vga_hsync_r <= 1'b0;
            vga_vsync_r <= 1'b0;
        end else begin
            hs_r    <= cga_hsync;
            vs_r    <= cga_vsync;
            vs_d1_r <= vs_r;
            wr_x_r  <= wr_x_nxt_s;
            rd_x_r  <= rd_x_nxt_s;
            // Capture stays off until the first edge so a partial line is never shown
            if (hs_edge_s) begin
                wr_bank_r <= ~wr_bank_r;
                cap_en_r  <= 1'b1;
                if (wr_bank_r) begin
                    len1_r <= wr_x_r;
                end else begin
                    len0_r <= wr_x_r;
                end
            end
            hs_d1_r     <= (rd_x_r < HS_END);
            blank_r     <= (rd_x_r >= rd_len_s);
            vga_video_r <= blank_r ? 4'h0 : rd_data_r;
            vga_hsync_r <= hs_d1_r;
            vga_vsync_r <= vs_d1_r;
        end
    end

    assign vga_video = vga_video_r;
    assign vga_hsync = vga_hsync_r;
    assign vga_vsync = vga_vsync_r;

endmodule

// File: tb/tb_cga_line_doubler.sv
// Directed bench for cga_line_doubler: a cycle model of the doubler checks
// every output each clock, plus hand-computed spot values per scenario.
module tb_cga_line_doubler;

    localparam int LP = 912;
    localparam int HW = 108;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cga_pix_en = 1'b0;
    logic [3:0] cga_video = 4'h0;
    logic       cga_hsync = 1'b0;
    logic       cga_vsync = 1'b0;
    logic [3:0] vga_video;
    logic       vga_hsync;
    logic       vga_vsync;

    always #5 clk = ~clk;

    cga_line_doubler #(.LINE_PIX(LP), .HSYNC_W(HW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cga_pix_en (cga_pix_en),
        .cga_video  (cga_video),
        .cga_hsync  (cga_hsync),
        .cga_vsync  (cga_vsync),
        .vga_video  (vga_video),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int         m_rd;
    logic       m_hs_prev;
    logic [3:0] m_vid_d1, m_vid_out;
    logic       m_hs_d1, m_hs_out;
    logic       m_vs1, m_vs2, m_vs_out;
    logic       m_cap_on;
    int         m_cap_n, m_disp_n;
    logic [3:0] m_cap [LP];
    logic [3:0] m_disp [LP];

    logic [3:0] obs_vid [4096];
    logic       obs_hs [4096];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pix_val(input int i, input int mode);
        if (i >= LP) return 4'h9;
        if (mode == 0) return 4'(i % 16);
        return 4'((3 * i + 1) % 16);
    endfunction

    task automatic model_reset();
        m_rd = 0; m_hs_prev = 1'b0;
        m_vid_d1 = 4'h0; m_vid_out = 4'h0;
        m_hs_d1 = 1'b0; m_hs_out = 1'b0;
        m_vs1 = 1'b0; m_vs2 = 1'b0; m_vs_out = 1'b0;
        m_cap_on = 1'b0; m_cap_n = 0; m_disp_n = 0;
    endtask

    task automatic model_clock();
        logic [3:0] src;
        bit         edge_s;
        if (reset) begin
            model_reset();
        end else begin
            src = (m_rd < m_disp_n) ? m_disp[m_rd] : 4'h0;
            m_vid_out = m_vid_d1; m_vid_d1 = src;
            m_hs_out = m_hs_d1;   m_hs_d1 = (m_rd < HW);
            m_vs_out = m_vs2; m_vs2 = m_vs1; m_vs1 = cga_vsync;
            edge_s = cga_hsync && !m_hs_prev;
            m_hs_prev = cga_hsync;
            if (edge_s) begin
                for (int i = 0; i < LP; i++) m_disp[i] = m_cap[i];
                m_disp_n = m_cap_n;
                m_cap_on = 1'b1;
                m_cap_n = 0;
                m_rd = 0;
            end else begin
                m_rd = (m_rd + 1) % LP;
            end
            if (cga_pix_en && m_cap_on && m_cap_n < LP) begin
                m_cap[m_cap_n] = cga_video;
                m_cap_n++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_eq("vga_video", {28'h0, vga_video}, {28'h0, m_vid_out});
        check_eq("vga_hsync", {31'h0, vga_hsync}, {31'h0, m_hs_out});
        check_eq("vga_vsync", {31'h0, vga_vsync}, {31'h0, m_vs_out});
        if ($urandom_range(0, 7) == 0) cga_vsync = ~cga_vsync;
    endtask

    task automatic run_line(input int npix, input bit coinc, input logic [3:0] cval,
                            input int mode, input int min_cyc);
        int cyc;
        cga_hsync = 1'b1; cga_pix_en = coinc; cga_video = cval;
        step();
        obs_vid[0] = vga_video; obs_hs[0] = vga_hsync;
        cga_hsync = 1'b0; cga_pix_en = 1'b0;
        step();
        obs_vid[1] = vga_video; obs_hs[1] = vga_hsync;
        cyc = 2;
        for (int i = (coinc ? 1 : 0); i < npix; i++) begin
            cga_pix_en = 1'b1; cga_video = pix_val(i, mode);
            step();
            obs_vid[cyc] = vga_video; obs_hs[cyc] = vga_hsync; cyc++;
            cga_pix_en = 1'b0;
            step();
            obs_vid[cyc] = vga_video; obs_hs[cyc] = vga_hsync; cyc++;
        end
        while (cyc < min_cyc) begin
            step();
            obs_vid[cyc] = vga_video; obs_hs[cyc] = vga_hsync; cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 1; j <= n; j++) begin
            step();
            obs_vid[j] = vga_video; obs_hs[j] = vga_hsync;
        end
    endtask

    // Async reset: outputs clear without waiting for a clock edge
    task automatic reset_pulse();
        reset = 1'b1;
        cga_pix_en = 1'($urandom_range(0, 1));
        cga_video = 4'($urandom_range(0, 15));
        cga_hsync = 1'($urandom_range(0, 1));
        #1;
        check_eq("rst_async_video", {28'h0, vga_video}, 32'h0);
        check_eq("rst_async_hsync", {31'h0, vga_hsync}, 32'h0);
        check_eq("rst_async_vsync", {31'h0, vga_vsync}, 32'h0);
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            cga_pix_en = 1'($urandom_range(0, 1));
            cga_video = 4'($urandom_range(0, 15));
            cga_hsync = 1'($urandom_range(0, 1));
        end
        cga_pix_en = 1'b0; cga_video = 4'h0; cga_hsync = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle_spots();
        idle(1830);
        check_eq("idle_hs_1",   {31'h0, obs_hs[1]},   32'h0);
        check_eq("idle_hs_2",   {31'h0, obs_hs[2]},   32'h1);
        check_eq("idle_hs_109", {31'h0, obs_hs[109]}, 32'h1);
        check_eq("idle_hs_110", {31'h0, obs_hs[110]}, 32'h0);
        check_eq("idle_hs_914", {31'h0, obs_hs[914]}, 32'h1);
        check_eq("idle_hs_1022", {31'h0, obs_hs[1022]}, 32'h0);
        check_eq("idle_vid_500", {28'h0, obs_vid[500]}, 32'h0);
    endtask

    initial begin
        model_reset();
        #2;
        reset_pulse();
        idle_spots();

        // A: first edge opens capture; 912 pixels of x mod 16
        run_line(912, 1'b0, 4'h0, 0, 0);
        check_eq("first_line_black", {28'h0, obs_vid[900]}, 32'h0);
        // B: short line while A is shown twice
        run_line(400, 1'b0, 4'h0, 1, 1826);
        check_eq("dbl_p0",    {28'h0, obs_vid[2]},   32'h0);
        check_eq("dbl_p1",    {28'h0, obs_vid[3]},   32'h1);
        check_eq("dbl_p15",   {28'h0, obs_vid[17]},  32'hF);
        check_eq("dbl_p911",  {28'h0, obs_vid[913]}, 32'hF);
        check_eq("dbl_2nd_p0", {28'h0, obs_vid[914]}, 32'h0);
        check_eq("dbl_2nd_p1", {28'h0, obs_vid[915]}, 32'h1);
        // C: 1000 strobes while B is shown
        run_line(1000, 1'b0, 4'h0, 1, 0);
        check_eq("short_p399", {28'h0, obs_vid[401]},  32'hE);
        check_eq("short_p400", {28'h0, obs_vid[402]},  32'h0);
        check_eq("short_p911", {28'h0, obs_vid[913]},  32'h0);
        check_eq("short_2nd_p0", {28'h0, obs_vid[914]}, 32'h1);
        check_eq("short_2nd_p399", {28'h0, obs_vid[1313]}, 32'hE);
        check_eq("short_2nd_p400", {28'h0, obs_vid[1314]}, 32'h0);
        // D: coincident edge+pixel 4'hA while C is shown
        run_line(300, 1'b1, 4'hA, 0, 1300);
        check_eq("ovf_p0",   {28'h0, obs_vid[2]},   32'h1);
        check_eq("ovf_p911", {28'h0, obs_vid[913]}, 32'hE);
        check_eq("ovf_2nd_p0", {28'h0, obs_vid[914]}, 32'h1);
        // E: D is shown; 300 pixels of a new line, then reset mid-line
        run_line(300, 1'b0, 4'h0, 0, 0);
        check_eq("coinc_p0",   {28'h0, obs_vid[2]},   32'hA);
        check_eq("coinc_p1",   {28'h0, obs_vid[3]},   32'h1);
        check_eq("coinc_p299", {28'h0, obs_vid[301]}, 32'hB);
        check_eq("coinc_p300", {28'h0, obs_vid[302]}, 32'h0);
        check_eq("coinc_hs_1", {31'h0, obs_hs[1]},    32'h0);
        check_eq("coinc_hs_2", {31'h0, obs_hs[2]},    32'h1);

        reset_pulse();
        idle_spots();
        // After reset: first edge still black, second edge shows the new line
        run_line(100, 1'b0, 4'h0, 0, 400);
        check_eq("post_rst_black_2",  {28'h0, obs_vid[2]},  32'h0);
        check_eq("post_rst_black_50", {28'h0, obs_vid[50]}, 32'h0);
        run_line(10, 1'b0, 4'h0, 0, 500);
        check_eq("post_rst_p0",  {28'h0, obs_vid[2]},   32'h0);
        check_eq("post_rst_p99", {28'h0, obs_vid[101]}, 32'h3);
        check_eq("post_rst_p100", {28'h0, obs_vid[102]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
